// File: rtl/lane_sum_reducer.sv
// Multi-cycle reducer: captures a vector of unsigned lane products and sums it
// LANES_PER_CYCLE lanes per clock, presenting the total through a valid/ready handshake.
module lane_sum_reducer #(
    parameter int unsigned NUM_LANES       = 240,
    parameter int unsigned IN_WIDTH        = 17,
    parameter int unsigned LANES_PER_CYCLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES*IN_WIDTH-1:0] P_flat,
    output logic [IN_WIDTH+$clog2(NUM_LANES)-1:0] sum_out,
    output logic                          sum_valid,
    input  logic                          sum_ready
);

    localparam int unsigned NBEATS    = NUM_LANES / LANES_PER_CYCLE;
    localparam int unsigned ACC_WIDTH = IN_WIDTH + $clog2(NUM_LANES);
    localparam int unsigned BUF_WIDTH = NUM_LANES * IN_WIDTH;
    localparam int unsigned SLICE_W   = LANES_PER_CYCLE * IN_WIDTH;
    localparam int unsigned BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StDone
    } state_e;

    state_e                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   sum_out_q;
    logic [BUF_WIDTH-1:0]   buf_q;
    logic [ACC_WIDTH-1:0]   beat_sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   last_beat;

    // The buffer is shifted down one slice per beat, so the current beat's lanes
    // always sit in the low SLICE_W bits.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES_PER_CYCLE; k++) begin
            beat_sum = beat_sum + ACC_WIDTH'(buf_q[k*IN_WIDTH +: IN_WIDTH]);
        end
        acc_next  = acc_q + beat_sum;
        last_beat = (beat_q == BEAT_W'(NBEATS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            acc_q     <= '0;
            sum_out_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q   <= '0;
                        beat_q  <= '0;
                        state_q <= StSum;
                    end
                end
                StSum: begin
                    acc_q <= acc_next;
                    if (last_beat) begin
                        sum_out_q <= acc_next;
                        state_q   <= StDone;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                StDone: begin
                    if (sum_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data-only storage: never observable without a fresh acceptance, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && in_valid) begin
            buf_q <= P_flat;
        end else if (state_q == StSum) begin
            buf_q <= buf_q >> SLICE_W;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign sum_valid = (state_q == StDone);
    assign sum_out   = sum_out_q;

endmodule

// File: tb/tb_lane_sum_reducer.sv
// Scoreboard bench for lane_sum_reducer: the driver queues hand-computed sums,
// a negedge monitor pops and checks them whenever sum_valid rises.
module tb_lane_sum_reducer;

    localparam int unsigned NUM_LANES = 240;
    localparam int unsigned IN_WIDTH  = 17;
    localparam int unsigned LPC       = 16;
    localparam int unsigned NBEATS    = NUM_LANES / LPC;
    localparam int unsigned ACC_W     = IN_WIDTH + $clog2(NUM_LANES);
    localparam int unsigned W         = NUM_LANES * IN_WIDTH;

    typedef struct {
        logic [ACC_W-1:0] sum;
        int               acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     P_flat;
    logic [ACC_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;

    exp_t             q[$];
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    logic             seen = 1'b0;
    logic [ACC_W-1:0] held;

    lane_sum_reducer #(
        .NUM_LANES      (NUM_LANES),
        .IN_WIDTH       (IN_WIDTH),
        .LANES_PER_CYCLE(LPC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .P_flat   (P_flat),
        .sum_out  (sum_out),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] mk_const(logic [IN_WIDTH-1:0] v);
        logic [W-1:0] r;
        for (int j = 0; j < NUM_LANES; j++) r[j*IN_WIDTH +: IN_WIDTH] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] mk_ramp(bit rev);
        logic [W-1:0] r;
        for (int j = 0; j < NUM_LANES; j++)
            r[j*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(rev ? (NUM_LANES - 1 - j) : j);
        return r;
    endfunction

    // Monitor: check total and latency on the rising edge of sum_valid, stability while held.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready && sum_valid) chk("ready_valid_exclusive", 32'd1, 32'd0);
            if (sum_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        chk("unexpected_sum_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sum_out", 32'(sum_out), 32'(e.sum));
                        chk("latency", 32'(cyc - e.acc_cyc), NBEATS);
                    end
                    held = sum_out;
                    seen = 1'b1;
                end else begin
                    chk("sum_out_hold", 32'(sum_out), 32'(held));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Waits (bounded) for in_ready, returns how many negedges it was low.
    task automatic wait_ready(output int lows);
        lows = 0;
        @(negedge clk);
        while (!in_ready && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        if (!in_ready) chk("wait_in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(logic [W-1:0] vec, logic [ACC_W-1:0] exp_sum, output int lows);
        exp_t e;
        wait_ready(lows);
        in_valid = 1'b1;
        P_flat   = vec;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.sum     = exp_sum;
        e.acc_cyc = cyc;
        q.push_back(e);
        chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int lows;
        int t;
        logic [ACC_W-1:0] snap;
        rst = 1'b1; in_valid = 1'b0; sum_ready = 1'b1; P_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_sum_valid", 32'(sum_valid), 32'd0);
        chk("reset_sum_out", 32'(sum_out), 32'd0);

        // All ones -> 240, then all-max -> 31457040.
        send(mk_const(17'd1), 25'd240, lows);
        send(mk_const(17'h1FFFF), 25'd31457040, lows);
        chk("idle_gap_before_accept", 32'(lows), NBEATS + 1);

        // Ramp then reversed ramp back-to-back.
        send(mk_ramp(1'b0), 25'd28680, lows);
        send(mk_ramp(1'b1), 25'd28680, lows);
        chk("back_to_back_ready_low", 32'(lows), NBEATS + 1);
        wait_ready(lows);

        // Backpressure in DONE with ignored in_valid pulses.
        sum_ready = 1'b0;
        send(mk_const(17'd5), 25'd1200, lows);
        t = 0;
        while (!sum_valid && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("sum_valid_seen", 32'(sum_valid), 32'd1);
        snap = sum_out;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            P_flat   = mk_const(17'd7);
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum_valid", 32'(sum_valid), 32'd1);
            chk("bp_sum_out", 32'(sum_out), 32'(snap));
        end
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(sum_valid), 32'd0);

        // Reset at beat 7 of SUM discards the in-flight sum.
        send(mk_const(17'd1), 25'd240, lows);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum_valid", 32'(sum_valid), 32'd0);
        chk("abort_sum_out", 32'(sum_out), 32'd0);
        send(mk_const(17'd2), 25'd480, lows);

        // Input changes during SUM must not leak into the result.
        send(mk_const(17'd3), 25'd720, lows);
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < NUM_LANES; j++) P_flat[j*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom);
            @(posedge clk); #1;
        end

        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk); t++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_sum_reducer.md
LANE_SUM_REDUCER -- requirements
Module: lane_sum_reducer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 240: number of product lanes per input vector.
REQ-002 SHALL have parameter IN_WIDTH, default 17: width of each unsigned lane product.
REQ-003 SHALL have parameter LANES_PER_CYCLE, default 16: lanes summed per accumulate cycle; NUM_LANES SHALL be an integer multiple of it.
REQ-004 SHALL derive localparam NBEATS = NUM_LANES/LANES_PER_CYCLE (default 15) and ACC_WIDTH = IN_WIDTH + clog2(NUM_LANES) (default 25).
REQ-005 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: P_flat holds a valid product vector.
REQ-008 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-009 SHALL have port P_flat, input, NUM_LANES*IN_WIDTH: lane j occupies bits [(j+1)*IN_WIDTH-1 -: IN_WIDTH].
REQ-010 SHALL have port sum_out, output, ACC_WIDTH: unsigned sum of all lanes of the accepted vector.
REQ-011 SHALL have port sum_valid, output, 1: sum_out is valid.
REQ-012 SHALL have port sum_ready, input, 1: downstream accepts sum_out.

Function
REQ-013 SHALL implement states IDLE, SUM, DONE, held in a registered state variable.
REQ-014 SHALL drive in_ready=1 only in IDLE and sum_valid=1 only in DONE, both decoded from registered state.
REQ-015 In IDLE, on in_valid&&in_ready at an edge: capture P_flat into an internal buffer, clear accumulator, set beat counter to 0, go to SUM.
REQ-016 In SUM, each edge SHALL add lanes [beat*LANES_PER_CYCLE .. beat*LANES_PER_CYCLE+LANES_PER_CYCLE-1] of the buffer, zero-extended to ACC_WIDTH, to the accumulator, and increment beat.
REQ-017 On the edge processing beat NBEATS-1, SHALL load sum_out with the final total and go to DONE; beat SHALL not wrap past NBEATS-1.
REQ-018 sum_valid SHALL rise exactly NBEATS rising edges after the accepting edge (default 15).
REQ-019 In DONE, sum_out and sum_valid SHALL hold stable while sum_ready=0; on sum_ready=1 at an edge, go to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; P_flat changes during SUM/DONE SHALL not affect the result.
REQ-021 Arithmetic SHALL be unsigned, modulo-free: ACC_WIDTH guarantees no overflow for all-ones input.
REQ-022 sum_out SHALL retain its last value in IDLE and SUM until overwritten by the next completion.
REQ-023 Throughput: one vector per NBEATS+2 cycles when sum_ready is held 1.

Reset
REQ-024 With rst=1 at an edge: state=IDLE, beat=0, accumulator=0, sum_out=0, sum_valid=0, in_ready=1 after that edge.
REQ-025 rst SHALL take priority over all handshakes, including mid-SUM and in DONE; any in-flight sum is discarded with no sum_valid pulse.
REQ-026 The capture buffer needs no reset; its content SHALL never reach sum_out without a fresh acceptance.

Verification
REQ-027 All lanes = 1, sum_ready=1 -> sum_valid high 15 edges after acceptance, sum_out = 240, back to IDLE next edge.
REQ-028 All lanes = 0x1FFFF -> sum_out = 31457040 (0x1DFFF10), no overflow.
REQ-029 Lane j = j -> sum_out = 28680; then lane j = 239-j back-to-back -> second sum_out = 28680, in_ready low throughout SUM/DONE.
REQ-030 Backpressure: sum_ready=0 for 5 cycles in DONE -> sum_out/sum_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-031 rst asserted at beat 7 of SUM -> next cycle IDLE, sum_out=0, sum_valid=0, in_ready=1; new vector (all lanes 2) -> sum_out = 480.
REQ-032 P_flat toggled randomly during SUM after accepting all-lanes-3 -> sum_out = 720.
